first1_normalizer: RTL and testbench

- Pipelined, parametrised successor to the combinational first-1 detector.
- Finds the leading one of a mantissa and reports its leading-zero count (LZC).
- Left-shifts the mantissa so its MSB is 1 and adjusts the accompanying exponent by the LZC.
- Sits after the add/sub and multiply datapaths, ahead of rounding. Uses valid/ready handshakes on both sides.

---
 rtl/first1_normalizer.sv | 123 ++++++++++++
 tb/tb_first1_normalizer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/first1_normalizer.sv
// Leading-one normalizer: LZC, left-shift to MSB=1, exponent adjust. Two register stages, 2-cycle latency, 1 beat/cycle.
// Valid/ready on both sides; a stalled output holds all out_* stable and backpressure reaches in_ready combinationally.
// Optional FIRST1_NORM_PERF_EN adds perf_cnt: consumed beats that needed a non-zero shift, saturating at 0xFFFF.
module first1_normalizer #(
    parameter int WIDTH = 24,
    parameter int EXP_W = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [CNT_W-1:0] out_lzc,
    output logic             out_zero,
`ifdef FIRST1_NORM_PERF_EN
    output logic             out_uflow,
    output logic [15:0]      perf_cnt
`else
    output logic             out_uflow
`endif
);

    // Priority encode from the MSB; an all-zero word reports WIDTH.
    function automatic logic [CNT_W-1:0] lead_zeros(input logic [WIDTH-1:0] m);
        logic [CNT_W-1:0] n;
        n = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) n = CNT_W'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    logic             s1_v;
    logic [WIDTH-1:0] s1_mant;
    logic [EXP_W-1:0] s1_exp;
    logic [CNT_W-1:0] s1_lzc;
    logic             s2_v;
    logic             s1_adv;
    logic             s2_adv;

    logic [CNT_W-1:0] in_lzc;
    logic             s1_zero;
    logic             s1_uflow;
    logic [WIDTH-1:0] s1_norm;
    logic [EXP_W-1:0] s1_adj_exp;

    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_v;
    assign in_lzc    = lead_zeros(in_mant);

    // Underflow compare runs in a width wide enough for both operands.
    always_comb begin
        s1_zero    = ~|s1_mant;
        s1_uflow   = 1'b0;
        s1_norm    = '0;
        s1_adj_exp = '0;
        if (!s1_zero) begin
            s1_norm  = s1_mant << s1_lzc;
            s1_uflow = ((EXP_W + CNT_W)'(s1_exp) < (EXP_W + CNT_W)'(s1_lzc));
            // Without underflow lzc <= exp, so narrowing lzc to EXP_W is lossless.
            if (!s1_uflow) s1_adj_exp = s1_exp - EXP_W'(s1_lzc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_mant <= '0;
            s1_exp  <= '0;
            s1_lzc  <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_mant <= in_mant;
                s1_exp  <= in_exp;
                s1_lzc  <= in_lzc;
            end
        end
    end

    // Output registers only load with a live beat, so a stall leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v      <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_lzc   <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_mant  <= s1_norm;
                out_exp   <= s1_adj_exp;
                out_lzc   <= s1_lzc;
                out_zero  <= s1_zero;
                out_uflow <= s1_uflow;
            end
        end
    end

`ifdef FIRST1_NORM_PERF_EN
    logic perf_hit;
    assign perf_hit = out_valid && out_ready && (out_lzc != '0) && !out_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (perf_hit && (perf_cnt != 16'hFFFF)) begin
            perf_cnt <= perf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_first1_normalizer.sv
// Directed bench for first1_normalizer at WIDTH=24, EXP_W=8: arithmetic, latency, stall/hold, reset flush.
module tb_first1_normalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_mant;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic [4:0]  out_lzc;
    logic        out_zero;
    logic        out_uflow;
`ifdef FIRST1_NORM_PERF_EN
    logic [15:0] perf_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int stale  = 0;

    first1_normalizer #(.WIDTH(24), .EXP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_lzc   (out_lzc),
        .out_zero  (out_zero),
`ifdef FIRST1_NORM_PERF_EN
        .out_uflow (out_uflow),
        .perf_cnt  (perf_cnt)
`else
        .out_uflow (out_uflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One beat with out_ready high: check 2-cycle latency then every output field.
    task automatic run_one(input string tag, input logic [23:0] m, input logic [7:0] e,
                           input logic [23:0] em, input logic [7:0] ee, input logic [4:0] el,
                           input logic ez, input logic eu);
        @(posedge clk); #1;
        in_valid = 1'b1; in_mant = m; in_exp = e;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_mant"},  32'(out_mant),  32'(em));
        chk({tag, "_exp"},   32'(out_exp),   32'(ee));
        chk({tag, "_lzc"},   32'(out_lzc),   32'(el));
        chk({tag, "_zero"},  32'(out_zero),  32'(ez));
        chk({tag, "_uflow"}, 32'(out_uflow), 32'(eu));
        @(negedge clk);
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_mant",  32'(out_mant),  32'd0);
        chk("rst_out_exp",   32'(out_exp),   32'd0);
        chk("rst_out_lzc",   32'(out_lzc),   32'd0);
        chk("rst_out_zero",  32'(out_zero),  32'd0);
        chk("rst_out_uflow", 32'(out_uflow), 32'd0);
`ifdef FIRST1_NORM_PERF_EN
        chk("rst_perf", 32'(perf_cnt), 32'd0);
`endif

        run_one("norm_msb", 24'h800000, 8'd127, 24'h800000, 8'd127, 5'd0,  1'b0, 1'b0);
        run_one("lsb_only", 24'h000001, 8'd100, 24'h800000, 8'd77,  5'd23, 1'b0, 1'b0);
        run_one("zero_in",  24'h000000, 8'd50,  24'h000000, 8'd0,   5'd24, 1'b1, 1'b0);
        run_one("uflow",    24'h000400, 8'd5,   24'h800000, 8'd0,   5'd13, 1'b0, 1'b1);
        run_one("exp_eq",   24'h0F0000, 8'd4,   24'hF00000, 8'd0,   5'd4,  1'b0, 1'b0);

        // Stall: two beats fill the pipe, third is held at the input.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mant = 24'h400000; in_exp = 8'd10;
        @(posedge clk); #1;
        in_mant = 24'h200000;
        @(negedge clk);
        chk("stall_ready_1beat", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_mant = 24'h100000;
        @(negedge clk);
        chk("stall_ready_full", 32'(in_ready),  32'd0);
        chk("stall_valid",      32'(out_valid), 32'd1);
        chk("stall_exp0",       32'(out_exp),   32'd9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_hold_exp",   32'(out_exp),   32'd9);
        chk("stall_hold_mant",  32'(out_mant),  32'h800000);
        chk("stall_hold_lzc",   32'(out_lzc),   32'd1);
        chk("stall_hold_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_ready", 32'(in_ready),  32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_exp1", 32'(out_exp),   32'd8);
        chk("drain_lzc1", 32'(out_lzc),   32'd2);
        chk("drain_v1",   32'(out_valid), 32'd1);
        @(negedge clk);
        chk("drain_exp2",  32'(out_exp),  32'd7);
        chk("drain_mant2", 32'(out_mant), 32'h800000);
        chk("drain_v2",    32'(out_valid), 32'd1);
        @(negedge clk);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Reset with two beats in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mant = 24'h200000; in_exp = 8'd20;
        @(posedge clk); #1;
        in_mant = 24'h100000;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_mant",  32'(out_mant),  32'd0);
        chk("mid_rst_lzc",   32'(out_lzc),   32'd0);
`ifdef FIRST1_NORM_PERF_EN
        chk("mid_rst_perf", 32'(perf_cnt), 32'd0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale_beat", 32'(stale), 32'd0);

        // Streamed beats with lzc 1, 0, 3.
        @(posedge clk); #1;
        in_valid = 1'b1; in_mant = 24'h400000; in_exp = 8'd10;
        @(posedge clk); #1;
        in_mant = 24'h800000;
        @(posedge clk); #1;
        in_mant = 24'h100000;
        @(negedge clk);
        chk("stream_exp_a", 32'(out_exp), 32'd9);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_exp_b", 32'(out_exp), 32'd10);
        @(negedge clk);
        chk("stream_exp_c", 32'(out_exp), 32'd7);
        chk("stream_lzc_c", 32'(out_lzc), 32'd3);
        @(negedge clk);
        chk("stream_empty", 32'(out_valid), 32'd0);
`ifdef FIRST1_NORM_PERF_EN
        chk("perf_count", 32'(perf_cnt), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
